// File: rtl/vga_sync_gen.sv
// VGA timing generator: divides the system clock down to the pixel rate,
// walks (pixel_x, pixel_y) over the full frame and decodes hsync/vsync,
// video_on and a frame_start pulse. All outputs except p_tick are registered
// from the next counter values, so coordinates and sync/blank flags always
// describe the same pixel.
module vga_sync_gen #(
   parameter int H_DISPLAY = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_DISPLAY = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33,
   parameter int TICK_DIV  = 4,
   parameter bit SYNC_POL  = 1'b0
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic       p_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] pixel_x,
   output logic [9:0] pixel_y,
   output logic       frame_start
);

   localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
   localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
   localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
   localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

   logic [CNT_W-1:0] r_tick_cnt;
   logic             r_run;
   logic             w_tick;
   logic [9:0]       w_x_next;
   logic [9:0]       w_y_next;
   logic             w_frame_wrap;
   logic             w_hs_act;
   logic             w_vs_act;
   logic             w_vis;

   logic [9:0]       r_pixel_x;
   logic [9:0]       r_pixel_y;
   logic             r_hsync;
   logic             r_vsync;
   logic             r_video_on;
   logic             r_frame_start;

   // Pixel-rate divider; r_run keeps p_tick low until the first edge after
   // reset so that edge always lands on (0,0), even when TICK_DIV is 1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_tick_cnt <= '0;
         r_run      <= 1'b0;
      end else begin
         r_run <= 1'b1;
         if (r_tick_cnt == TICK_LAST) r_tick_cnt <= '0;
         else                         r_tick_cnt <= r_tick_cnt + 1'b1;
      end
   end

   assign w_tick = r_run && (r_tick_cnt == TICK_LAST);

   // Next coordinates: advance on p_tick, wrap x at end of line, y at end of frame.
   always_comb begin
      w_x_next     = r_pixel_x;
      w_y_next     = r_pixel_y;
      w_frame_wrap = 1'b0;
      if (w_tick) begin
         if (r_pixel_x == X_LAST) begin
            w_x_next = '0;
            if (r_pixel_y == Y_LAST) begin
               w_y_next     = '0;
               w_frame_wrap = 1'b1;
            end else begin
               w_y_next = r_pixel_y + 10'd1;
            end
         end else begin
            w_x_next = r_pixel_x + 10'd1;
         end
      end
   end

   // Sync and blanking decode of the pixel about to be presented.
   always_comb begin
      w_hs_act = (w_x_next >= HS_FIRST) && (w_x_next <= HS_LAST);
      w_vs_act = (w_y_next >= VS_FIRST) && (w_y_next <= VS_LAST);
      w_vis    = (w_x_next < X_VIS) && (w_y_next < Y_VIS);
   end

   // Counters and decoded outputs load together so they never skew.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pixel_x     <= '0;
         r_pixel_y     <= '0;
         r_hsync       <= ~SYNC_POL;
         r_vsync       <= ~SYNC_POL;
         r_video_on    <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_pixel_x     <= w_x_next;
         r_pixel_y     <= w_y_next;
         r_hsync       <= w_hs_act ? SYNC_POL : ~SYNC_POL;
         r_vsync       <= w_vs_act ? SYNC_POL : ~SYNC_POL;
         r_video_on    <= w_vis;
         r_frame_start <= w_frame_wrap;
      end
   end

   assign p_tick      = w_tick;
   assign hsync       = r_hsync;
   assign vsync       = r_vsync;
   assign video_on    = r_video_on;
   assign pixel_x     = r_pixel_x;
   assign pixel_y     = r_pixel_y;
   assign frame_start = r_frame_start;

endmodule
